agc_timing_gen: RTL and testbench

//  Parametrised successor to the A2 timer. A fully synchronous timing generator

---
 rtl/agc_timing_if.sv | 31 +++
 rtl/agc_timing_gen.sv | 211 +++++++++++++++++++++
 tb/tb_agc_timing_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/agc_timing_if.sv
// Bundle of the timing generator's control inputs and timing outputs.
// The slave modport is the generator; the master modport is its controller or observer.
interface agc_timing_if #(
   parameter int NP = 5,
   parameter int NF = 4
);
   logic          STOP;
   logic          GO;
   logic          STEP;
   logic [3:0]    PHS;
   logic          RT;
   logic          CT;
   logic          WT;
   logic          ODDSET;
   logic          EVNSET;
   logic [NP-1:0] P;
   logic [3:0]    SB;
   logic          EDSET;
   logic [NF-1:0] FS;
   logic          GOJAM_;

   modport master (
      output STOP, GO, STEP,
      input  PHS, RT, CT, WT, ODDSET, EVNSET, P, SB, EDSET, FS, GOJAM_
   );

   modport slave (
      input  STOP, GO, STEP,
      output PHS, RT, CT, WT, ODDSET, EVNSET, P, SB, EDSET, FS, GOJAM_
   );
endinterface

// File: rtl/agc_timing_gen.sv
// Phase-slot divider, 4-phase sequencer, NP-stage Johnson ring, F-scaler and GOJAM FSM.
// Optional single-step while halted is enabled by defining TIMER_SSTEP_EN.
module agc_timing_gen #(
   parameter int PH_DIV    = 1,
   parameter int NP        = 5,
   parameter int NF        = 4,
   parameter int GOJAM_LEN = 2
) (
   input  logic        SIM_CLK,
   input  logic        SIM_RST_,
   agc_timing_if.slave bus
);

   localparam int DIV_W = (PH_DIV > 1) ? $clog2(PH_DIV) : 1;
   localparam int JAM_W = (GOJAM_LEN > 1) ? $clog2(GOJAM_LEN) : 1;
   localparam int KMAX  = 2 * NP - 1;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   // Ring pattern for Johnson index k: k ones from the bottom, then zeros shifting in.
   function automatic logic [NP-1:0] jpat(input int k);
      logic [NP-1:0] r;
      r = '0;
      for (int b = 0; b < NP; b++) begin
         r[b] = (k <= NP) ? (b < k) : (b >= k - NP);
      end
      return r;
   endfunction

   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       phs_q, phs_d;
   logic [NP-1:0]    p_q, p_d;
   logic [NF-1:0]    fs_q, fs_d;
   logic [JAM_W-1:0] jam_q, jam_d;
   state_t           state_q, state_d;
   logic             odd_q, odd_d;
   logic             evn_q, evn_d;
   logic             div_term;
   logic             rse;
   logic             adv;
   logic             at_end;
   logic             step_go;
   logic [3:0]       sb;

   assign div_term = (div_q == DIV_W'(PH_DIV - 1));
   assign rse      = div_term & phs_q[3];
   assign at_end   = (p_q == jpat(KMAX));

   always_comb begin
      div_d = div_q + DIV_W'(1);
      phs_d = phs_q;
      if (div_term) begin
         div_d = '0;
         phs_d = {phs_q[2:0], phs_q[3]};
      end
   end

   always_comb begin
      state_d = state_q;
      jam_d   = jam_q;
      adv     = 1'b0;
      if (bus.GO) begin
         state_d = ST_START;
         jam_d   = '0;
      end else begin
         case (state_q)
            ST_START: begin
               if (rse) begin
                  if (jam_q == JAM_W'(GOJAM_LEN - 1)) begin
                     state_d = ST_RUN;
                     jam_d   = '0;
                  end else begin
                     jam_d = jam_q + JAM_W'(1);
                  end
               end
            end
            ST_RUN: begin
               if (rse) begin
                  if (bus.STOP) begin
                     state_d = ST_HALT;
                  end else begin
                     adv = 1'b1;
                  end
               end
            end
            ST_HALT: begin
               if (rse) begin
                  if (!bus.STOP) begin
                     state_d = ST_RUN;
                     adv     = 1'b1;
                  end else if (step_go) begin
                     adv = 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_START;
               jam_d   = '0;
            end
         endcase
      end
   end

   // Parity of a Johnson index equals the XOR of its ring bits, so the
   // destination of an advance is odd exactly when the current ring XOR is 0.
   always_comb begin
      p_d   = p_q;
      fs_d  = fs_q;
      odd_d = 1'b0;
      evn_d = 1'b0;
      if (bus.GO || state_q == ST_START) begin
         p_d = '0;
      end else if (adv) begin
         p_d   = {p_q[NP-2:0], ~p_q[NP-1]};
         odd_d = ~(^p_q);
         evn_d = ^p_q;
         if (at_end) begin
            fs_d = fs_q + NF'(1);
         end
      end
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST_) begin
      if (!SIM_RST_) begin
         div_q   <= '0;
         phs_q   <= 4'b0001;
         p_q     <= '0;
         fs_q    <= '0;
         jam_q   <= '0;
         state_q <= ST_START;
         odd_q   <= 1'b0;
         evn_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         phs_q   <= phs_d;
         p_q     <= p_d;
         fs_q    <= fs_d;
         jam_q   <= jam_d;
         state_q <= state_d;
         odd_q   <= odd_d;
         evn_q   <= evn_d;
      end
   end

`ifdef TIMER_SSTEP_EN
   logic step_q;
   logic armed_q, armed_d;
   logic step_rise;

   assign step_rise = bus.STEP & ~step_q;
   assign step_go   = armed_q;

   // One armed advance per STEP edge; consumed by any advance taken in HALT.
   always_comb begin
      armed_d = armed_q;
      if (bus.GO) begin
         armed_d = 1'b0;
      end else if (state_q == ST_HALT) begin
         if (adv) begin
            armed_d = 1'b0;
         end else if (step_rise) begin
            armed_d = 1'b1;
         end
      end else begin
         armed_d = 1'b0;
      end
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST_) begin
      if (!SIM_RST_) begin
         step_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         step_q  <= bus.STEP;
         armed_q <= armed_d;
      end
   end
`else
   logic unused_step;
   assign unused_step = bus.STEP;
   assign step_go     = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sb
         if (2 * gi + 1 < 2 * NP) begin : g_on
            assign sb[gi] = (p_q == jpat(2 * gi + 1));
         end else begin : g_off
            assign sb[gi] = 1'b0;
         end
      end
   endgenerate

   assign bus.PHS    = phs_q;
   assign bus.RT     = phs_q[0];
   assign bus.CT     = phs_q[1];
   assign bus.WT     = phs_q[2];
   assign bus.ODDSET = odd_q;
   assign bus.EVNSET = evn_q;
   assign bus.P      = p_q;
   assign bus.SB     = sb;
   assign bus.EDSET  = at_end;
   assign bus.FS     = fs_q;
   assign bus.GOJAM_ = (state_q != ST_START);

endmodule

// File: tb/tb_agc_timing_gen.sv
// Randomized bench for agc_timing_gen: two configurations checked every cycle
// against an arithmetic model of slot position, ring index, F-scaler and run mode.
module tb_agc_timing_gen;

   logic clk = 1'b0;
   logic rst_a_n;
   logic rst_b_n;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   agc_timing_if #(.NP(5), .NF(4)) ifa ();
   agc_timing_if #(.NP(3), .NF(4)) ifb ();

   agc_timing_gen #(.PH_DIV(1), .NP(5), .NF(4), .GOJAM_LEN(2)) dut_a (
      .SIM_CLK (clk),
      .SIM_RST_(rst_a_n),
      .bus     (ifa)
   );

   agc_timing_gen #(.PH_DIV(3), .NP(3), .NF(4), .GOJAM_LEN(2)) dut_b (
      .SIM_CLK (clk),
      .SIM_RST_(rst_b_n),
      .bus     (ifb)
   );

   // mode: 0 = START, 1 = RUN, 2 = HALT
   typedef struct {
      int slot;
      int k;
      int fs;
      int mode;
      int jams;
      bit armed;
      bit step_prev;
      bit odd;
      bit evn;
   } mdl_t;

   mdl_t ma;
   mdl_t mb;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.slot = 0; m.k = 0; m.fs = 0; m.mode = 0; m.jams = 0;
      m.armed = 1'b0; m.step_prev = 1'b0; m.odd = 1'b0; m.evn = 1'b0;
      return m;
   endfunction

   function automatic int ring_of(input int k, input int np);
      if (k <= np) return (1 << k) - 1;
      return ((1 << np) - 1) & ~((1 << (k - np)) - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic mdl_step(inout mdl_t m, input int ph_div, input int np, input int nf,
                           input int glen, input logic go, input logic stop, input logic step);
      bit rse;
      bit adv;
      rse = (m.slot == 4 * ph_div - 1);
      adv = 1'b0;
      if (go) begin
         m.mode = 0; m.jams = 0; m.k = 0; m.armed = 1'b0;
      end else begin
         case (m.mode)
            0: if (rse) begin
                  m.jams++;
                  if (m.jams == glen) begin m.mode = 1; m.jams = 0; end
               end
            1: if (rse) begin
                  if (stop) m.mode = 2;
                  else adv = 1'b1;
               end
            default: begin
               if (rse && !stop) begin
                  m.mode = 1;
                  adv = 1'b1;
               end else if (rse && m.armed) begin
                  adv = 1'b1;
               end
               if (adv) m.armed = 1'b0;
`ifdef TIMER_SSTEP_EN
               else if (step && !m.step_prev) m.armed = 1'b1;
`endif
            end
         endcase
      end
      m.odd = 1'b0;
      m.evn = 1'b0;
      if (adv) begin
         if (m.k == 2 * np - 1) m.fs = (m.fs + 1) % (1 << nf);
         m.k   = (m.k + 1) % (2 * np);
         m.odd = (m.k % 2 == 1);
         m.evn = !m.odd;
      end
      m.step_prev = step;
      m.slot = (m.slot + 1) % (4 * ph_div);
   endtask

   task automatic check_dut(input string id, input mdl_t m, input int ph_div, input int np,
                            input logic [3:0] phs, input logic rt, input logic ct,
                            input logic wt, input logic odd, input logic evn,
                            input logic [31:0] p, input logic [3:0] sb, input logic edset,
                            input logic [31:0] fs, input logic gojam);
      logic [3:0] exp_phs;
      logic [3:0] exp_sb;
      exp_phs = 4'(1 << (m.slot / ph_div));
      exp_sb  = '0;
      for (int i = 0; i < 4; i++) if (m.k == 2 * i + 1) exp_sb[i] = 1'b1;
      chk({id, ".phs"},    32'(phs),   32'(exp_phs));
      chk({id, ".rt"},     32'(rt),    32'(exp_phs[0]));
      chk({id, ".ct"},     32'(ct),    32'(exp_phs[1]));
      chk({id, ".wt"},     32'(wt),    32'(exp_phs[2]));
      chk({id, ".p"},      p,          32'(ring_of(m.k, np)));
      chk({id, ".sb"},     32'(sb),    32'(exp_sb));
      chk({id, ".edset"},  32'(edset), 32'(m.k == 2 * np - 1));
      chk({id, ".fs"},     fs,         32'(m.fs));
      chk({id, ".gojam_"}, 32'(gojam), 32'(m.mode != 0));
      chk({id, ".oddset"}, 32'(odd),   32'(m.odd));
      chk({id, ".evnset"}, 32'(evn),   32'(m.evn));
   endtask

   task automatic check_reset_consts(input string id, input logic [3:0] phs,
                                     input logic [31:0] p, input logic gojam,
                                     input logic [31:0] fs, input logic odd);
      chk({id, ".rst.phs"},    32'(phs),   32'h1);
      chk({id, ".rst.p"},      p,          32'h0);
      chk({id, ".rst.gojam_"}, 32'(gojam), 32'h0);
      chk({id, ".rst.fs"},     fs,         32'h0);
      chk({id, ".rst.oddset"}, 32'(odd),   32'h0);
   endtask

   // Called at a falling edge; checks both DUTs, drives inputs, advances both models.
   task automatic run_cycles(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         check_dut("A", ma, 1, 5, ifa.PHS, ifa.RT, ifa.CT, ifa.WT, ifa.ODDSET, ifa.EVNSET,
                   32'(ifa.P), ifa.SB, ifa.EDSET, 32'(ifa.FS), ifa.GOJAM_);
         check_dut("B", mb, 3, 3, ifb.PHS, ifb.RT, ifb.CT, ifb.WT, ifb.ODDSET, ifb.EVNSET,
                   32'(ifb.P), ifb.SB, ifb.EDSET, 32'(ifb.FS), ifb.GOJAM_);
         if (rnd) begin
            ifa.GO   = ($urandom_range(0, 79) == 0);
            ifb.GO   = ($urandom_range(0, 119) == 0);
            if ($urandom_range(0, 31) == 0) ifa.STOP = ~ifa.STOP;
            if ($urandom_range(0, 31) == 0) ifb.STOP = ~ifb.STOP;
            ifa.STEP = ($urandom_range(0, 3) == 0);
            ifb.STEP = ($urandom_range(0, 3) == 0);
         end else begin
            ifa.GO = 1'b0; ifa.STOP = 1'b0; ifa.STEP = 1'b0;
            ifb.GO = 1'b0; ifb.STOP = 1'b0; ifb.STEP = 1'b0;
         end
         @(posedge clk);
         if (rst_a_n) mdl_step(ma, 1, 5, 4, 2, ifa.GO, ifa.STOP, ifa.STEP);
         else         ma = mdl_reset();
         if (rst_b_n) mdl_step(mb, 3, 3, 4, 2, ifb.GO, ifb.STOP, ifb.STEP);
         else         mb = mdl_reset();
         @(negedge clk);
      end
   endtask

   initial begin
      int guard;
      rst_a_n  = 1'b0;
      rst_b_n  = 1'b0;
      ifa.GO   = 1'b0; ifa.STOP = 1'b0; ifa.STEP = 1'b0;
      ifb.GO   = 1'b0; ifb.STOP = 1'b0; ifb.STEP = 1'b0;
      ma = mdl_reset();
      mb = mdl_reset();
      repeat (2) @(negedge clk);
      check_reset_consts("A", ifa.PHS, 32'(ifa.P), ifa.GOJAM_, 32'(ifa.FS), ifa.ODDSET);
      check_reset_consts("B", ifb.PHS, 32'(ifb.P), ifb.GOJAM_, 32'(ifb.FS), ifb.ODDSET);
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      // Free run: jam period, then more than one full ring wrap on A.
      run_cycles(100, 1'b0);
      run_cycles(1500, 1'b1);

      // Asynchronous reset of B part-way through a phase slot.
      guard = 0;
      while (mb.slot % 3 == 0 && guard < 10) begin
         run_cycles(1, 1'b1);
         guard++;
      end
      rst_b_n = 1'b0;
      #1;
      check_reset_consts("B", ifb.PHS, 32'(ifb.P), ifb.GOJAM_, 32'(ifb.FS), ifb.ODDSET);
      mb = mdl_reset();
      run_cycles(3, 1'b1);
      rst_b_n = 1'b1;
      run_cycles(400, 1'b1);

      // Asynchronous reset of A in the middle of random operation.
      rst_a_n = 1'b0;
      #1;
      check_reset_consts("A", ifa.PHS, 32'(ifa.P), ifa.GOJAM_, 32'(ifa.FS), ifa.ODDSET);
      ma = mdl_reset();
      run_cycles(2, 1'b1);
      rst_a_n = 1'b1;
      run_cycles(60, 1'b0);
      run_cycles(400, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
